// File: rtl/vliw_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module   : vliw_writeback_stage
// Purpose  : Final stage of the two-slot (ALU + MEM) VLIW datapath. Accepts one
//            executed bundle per cycle and parks bundles whose MEM slot is a
//            load until the data-memory response arrives. Both slot results
//            are then committed to the register file in a single cycle, and
//            same-destination conflicts are resolved in favour of the MEM slot.
// Ports    : clk, reset                 - clock, synchronous active-high reset
//            in_valid / in_ready        - bundle handshake from execute
//            in_alu_* / in_mem_*        - executed bundle contents
//            mem_rsp_valid/_data        - data-memory load response
//            mem_regWrite/_rd/_writeData - register-file MEM write port
//            alu_regWrite/_rd/_writeData - register-file ALU write port
//            load_err                   - sticky load-timeout flag
//            conflict_cnt               - ALU writes dropped on rd conflict
//            retired_cnt                - committed bundles (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module vliw_writeback_stage #(
    parameter int DATA_W       = 32,
    parameter int REG_AW       = 3,
    parameter int LOAD_TIMEOUT = 16,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_alu_wen,
    input  logic [REG_AW-1:0] in_alu_rd,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic              in_mem_wen,
    input  logic              in_mem_isLoad,
    input  logic [REG_AW-1:0] in_mem_rd,
    input  logic [DATA_W-1:0] in_mem_result,

    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,

    output logic              mem_regWrite,
    output logic [REG_AW-1:0] mem_rd,
    output logic [DATA_W-1:0] mem_writeData,
    output logic              alu_regWrite,
    output logic [REG_AW-1:0] alu_rd,
    output logic [DATA_W-1:0] alu_writeData,

    output logic              load_err,
    output logic [CNT_W-1:0]  conflict_cnt,
    output logic [31:0]       retired_cnt
);

    // Wait counter must be at least one bit wide even when LOAD_TIMEOUT == 1.
    localparam int                WAIT_W    = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(LOAD_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_in_ready;

    // Hold registers for the bundle currently owned by the stage.
    logic                r_h_alu_wen;
    logic [REG_AW-1:0]   r_h_alu_rd;
    logic [DATA_W-1:0]   r_h_alu_data;
    logic                r_h_mem_wen;
    logic [REG_AW-1:0]   r_h_mem_rd;
    logic [DATA_W-1:0]   r_h_mem_data;
    logic [WAIT_W-1:0]   r_wait_cnt;

    logic                w_accept;
    logic                w_in_is_load;
    logic                w_in_wait;
    logic                w_timeout;

    // Values that will be driven on the write ports during the next cycle.
    logic                w_fire;
    logic                w_alu_wen;
    logic [REG_AW-1:0]   w_alu_rd;
    logic [DATA_W-1:0]   w_alu_data;
    logic                w_mem_wen;
    logic [REG_AW-1:0]   w_mem_rd;
    logic [DATA_W-1:0]   w_mem_data;
    logic                w_conflict;

    assign in_ready     = r_in_ready;
    assign w_accept     = in_valid & r_in_ready;
    assign w_in_is_load = in_mem_wen & in_mem_isLoad;
    assign w_in_wait    = (r_state == S_WAIT);
    // A response arriving on the final wait cycle still wins over the timeout.
    assign w_timeout    = w_in_wait & ~mem_rsp_valid & (r_wait_cnt == WAIT_LAST);

    // ------------------------------------------------------------------------
    // Commit source selection: a parked load (response or timeout) or a
    // freshly accepted non-load bundle that bypasses the hold registers.
    // ------------------------------------------------------------------------
    always_comb begin
        w_fire     = 1'b0;
        w_alu_wen  = r_h_alu_wen;
        w_alu_rd   = r_h_alu_rd;
        w_alu_data = r_h_alu_data;
        w_mem_wen  = r_h_mem_wen;
        w_mem_rd   = r_h_mem_rd;
        w_mem_data = r_h_mem_data;

        if (w_in_wait) begin
            if (mem_rsp_valid) begin
                w_fire     = 1'b1;
                w_mem_data = mem_rsp_data;
            end else if (w_timeout) begin
                // Abandoned load: the ALU slot still retires, the MEM slot is dropped.
                w_fire     = 1'b1;
                w_mem_wen  = 1'b0;
            end
        end else if (w_accept && !w_in_is_load) begin
            w_fire     = 1'b1;
            w_alu_wen  = in_alu_wen;
            w_alu_rd   = in_alu_rd;
            w_alu_data = in_alu_result;
            w_mem_wen  = in_mem_wen;
            w_mem_rd   = in_mem_rd;
            w_mem_data = in_mem_result;
        end

        // A suppressed MEM write has w_mem_wen=0, so it never counts as a conflict.
        w_conflict = w_mem_wen & w_alu_wen & (w_mem_rd == w_alu_rd);
    end

    // ------------------------------------------------------------------------
    // Next-state logic.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_COMMIT: begin
                if (w_accept) begin
                    w_state_nxt = w_in_is_load ? S_WAIT : S_COMMIT;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                if (mem_rsp_valid || w_timeout) begin
                    w_state_nxt = S_COMMIT;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // State, hold registers, registered write ports and status counters.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_in_ready    <= 1'b1;
            r_h_alu_wen   <= 1'b0;
            r_h_alu_rd    <= '0;
            r_h_alu_data  <= '0;
            r_h_mem_wen   <= 1'b0;
            r_h_mem_rd    <= '0;
            r_h_mem_data  <= '0;
            r_wait_cnt    <= '0;
            mem_regWrite  <= 1'b0;
            mem_rd        <= '0;
            mem_writeData <= '0;
            alu_regWrite  <= 1'b0;
            alu_rd        <= '0;
            alu_writeData <= '0;
            load_err      <= 1'b0;
            conflict_cnt  <= '0;
            retired_cnt   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != S_WAIT);

            if (w_accept) begin
                r_h_alu_wen  <= in_alu_wen;
                r_h_alu_rd   <= in_alu_rd;
                r_h_alu_data <= in_alu_result;
                r_h_mem_wen  <= in_mem_wen;
                r_h_mem_rd   <= in_mem_rd;
                r_h_mem_data <= in_mem_result;
                r_wait_cnt   <= '0;
            end else if (w_in_wait) begin
                r_wait_cnt   <= r_wait_cnt + WAIT_W'(1);
            end

            if (w_fire) begin
                mem_regWrite  <= w_mem_wen;
                mem_rd        <= w_mem_rd;
                mem_writeData <= w_mem_data;
                alu_regWrite  <= w_alu_wen & ~w_conflict;
                alu_rd        <= w_alu_rd;
                alu_writeData <= w_alu_data;
                retired_cnt   <= retired_cnt + 32'd1;
                if (w_conflict && (conflict_cnt != CNT_MAX)) begin
                    conflict_cnt <= conflict_cnt + CNT_W'(1);
                end
            end else begin
                // Indices and data hold their last values between commits.
                mem_regWrite  <= 1'b0;
                alu_regWrite  <= 1'b0;
            end

            if (w_timeout) begin
                load_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
